dac_cmd_scheduler: RTL and testbench
====================================

Name: dac_cmd_scheduler

Overview:
Shares one DAC_SPI serializer among NUM_CH DAC channels. Per-channel update requests are latched into shadow registers and granted round-robin. For each grant the block drives comm/addr/data and ext_ctrl for one fixed-length frame, then enforces an inter-frame gap. It sits between the slow-control register file and DAC_SPI.

Parameters:
NUM_CH, 4, number of DAC channels; legal range 2..16.
CMD_WRITE, 4'h3, 4-bit command code driven on dac_comm for every frame.
ADDR_BASE, 4'h0, DAC address of channel 0; channel i uses ADDR_BASE+i, truncated to 4 bits.
FRAME_CYCLES, 2080, clk cycles that dac_ext_ctrl is held high per frame; must be at least 1.
GAP_CYCLES, 16, clk cycles that dac_ext_ctrl is held low after each frame; must be at least 1.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  synchronous, active-low reset.
enable  in  1  1 = new grants allowed; 0 = finish the current frame, then hold.
wr_valid  in  1  write strobe for one channel update; accepted every cycle (no backpressure).
wr_chan  in  $clog2(NUM_CH)  target channel; values >= NUM_CH are ignored.
wr_data  in  16  DAC code for that channel.
pending  out  NUM_CH  per-channel "update waiting" flags.
busy  out  1  1 in any state except IDLE.
done  out  1  one-cycle pulse when a frame's gap completes.
done_chan  out  $clog2(NUM_CH)  channel of the completed frame; valid while done=1.
dac_comm  out  4  command to DAC_SPI comm.
dac_addr  out  4  address to DAC_SPI addr.
dac_data  out  16  data to DAC_SPI data.
dac_ext_ctrl  out  1  start/hold to DAC_SPI ext_ctrl.

Behaviour:
- Reset (rst_n=0 at a clk edge) applies regardless of state, including mid-frame:
  - state=IDLE; pending=0; shadow registers=0; round-robin pointer=0.
  - dac_ext_ctrl=0, dac_comm=0, dac_addr=0, dac_data=0.
  - busy=0, done=0, done_chan=0.
- Write capture:
  - A cycle with wr_valid=1 and wr_chan<NUM_CH loads shadow[wr_chan]<=wr_data and sets pending[wr_chan].
  - A later write before the grant overwrites the shadow value. Writes coalesce; only the last value is sent.
- States: IDLE, LOAD, ACTIVE, GAP.
- IDLE:
  - If enable=1 and pending!=0, grant the first pending channel searching upward from pointer, wrapping NUM_CH-1 to 0. Then go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - Register dac_comm=CMD_WRITE, dac_addr=ADDR_BASE+grant, dac_data=shadow[grant].
  - Clear pending[grant], unless a write to the same channel occurs in this cycle. In that case pending stays 1, the new value goes to the shadow register, and the latched frame data keeps the old value.
  - Set pointer=grant+1, wrapping to 0.
- ACTIVE:
  - dac_ext_ctrl=1 for exactly FRAME_CYCLES cycles; then go to GAP.
  - dac_comm, dac_addr and dac_data stay stable from LOAD through the end of GAP.
- GAP:
  - dac_ext_ctrl=0 for exactly GAP_CYCLES cycles.
  - On the last GAP cycle, assert done=1 with done_chan=grant for one cycle and go to IDLE.
- A grant can occur on the cycle after done. The minimum period between frames is 1+FRAME_CYCLES+GAP_CYCLES+1 cycles.
- enable=0 only blocks the IDLE-to-LOAD transition. It never truncates a frame.
- Writes are accepted in every state, including while their channel is being transmitted.
- dac_ext_ctrl is registered and glitch-free. It rises one cycle after LOAD.
- Cycle counter width is $clog2(max(FRAME_CYCLES,GAP_CYCLES)+1) bits. It is reloaded on every state entry.

Test Plan:
- Reset, then one write (chan 2, 16'hA5C3) -> LOAD 1 cycle later; dac_addr=4'h2, dac_data=16'hA5C3, dac_comm=4'h3; ext_ctrl high exactly 2080 cycles, low 16; done pulse with done_chan=2; pending=0.
- Writes to chans 0, 1 and 3 in the same idle window -> frames in order 0, 1, 3; pointer wraps; then write chan 0 while pointer=0 -> chan 0 served next.
- Two writes to chan 1 (16'h1111, then 16'h2222) before grant -> exactly one frame, with dac_data=16'h2222.
- Write to chan 1 (16'h3333) during chan 1's ACTIVE frame -> current frame data unchanged; second frame follows with 16'h3333. Repeat with the write landing exactly in LOAD -> same result.
- enable=0 with pending=4'b1111 -> no grant; drop enable mid-frame -> frame completes, no new grant until enable=1.
- rst_n=0 mid-ACTIVE -> next cycle ext_ctrl=0, pending=0, busy=0; write to wr_chan>=NUM_CH (NUM_CH=3) -> ignored.

Source files
------------

// File: rtl/dac_cmd_scheduler.sv
// Round-robin scheduler sharing one DAC serializer among NUM_CH channels.
// Channel updates are latched into shadow registers, granted in turn, and
// sent as fixed-length frames followed by a fixed inter-frame gap.
module dac_cmd_scheduler #(
  parameter int unsigned NUM_CH       = 4,
  parameter logic [3:0]  CMD_WRITE    = 4'h3,
  parameter logic [3:0]  ADDR_BASE    = 4'h0,
  parameter int unsigned FRAME_CYCLES = 2080,
  parameter int unsigned GAP_CYCLES   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      wr_valid,
  input  logic [$clog2(NUM_CH)-1:0] wr_chan,
  input  logic [15:0]               wr_data,
  output logic [NUM_CH-1:0]         pending,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NUM_CH)-1:0] done_chan,
  output logic [3:0]                dac_comm,
  output logic [3:0]                dac_addr,
  output logic [15:0]               dac_data,
  output logic                      dac_ext_ctrl
);

  localparam int unsigned CHW     = $clog2(NUM_CH);
  localparam int unsigned MAX_CYC = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CHW-1:0]  grant, grant_nxt;
  logic [CHW-1:0]  ptr, ptr_nxt;
  logic [CHW-1:0]  sel;
  logic            sel_found;
  int unsigned     rr_idx;
  logic [15:0]     shadow [NUM_CH];
  logic            wr_hit;

  logic [NUM_CH-1:0] pending_nxt;
  logic              busy_nxt, done_nxt, ext_nxt;
  logic [CHW-1:0]    done_chan_nxt;
  logic [3:0]        comm_nxt, addr_nxt;
  logic [15:0]       data_nxt;

  // Only in-range channel numbers update the shadow registers.
  assign wr_hit = wr_valid && ({1'b0, wr_chan} < (CHW+1)'(NUM_CH));

  // Shadow registers: last write per channel wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) shadow[i] <= '0;
    end else if (wr_hit) begin
      shadow[wr_chan] <= wr_data;
    end
  end

  // Round-robin search: first pending channel at or above ptr, wrapping.
  always_comb begin
    sel       = ptr;
    sel_found = 1'b0;
    rr_idx    = 0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      rr_idx = (32'(ptr) + 32'(i)) % NUM_CH;
      if (!sel_found && pending[CHW'(rr_idx)]) begin
        sel_found = 1'b1;
        sel       = CHW'(rr_idx);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    grant_nxt     = grant;
    ptr_nxt       = ptr;
    pending_nxt   = pending;
    comm_nxt      = dac_comm;
    addr_nxt      = dac_addr;
    data_nxt      = dac_data;
    done_chan_nxt = done_chan;

    case (state)
      S_IDLE: begin
        if (enable && sel_found) begin
          state_nxt = S_LOAD;
          grant_nxt = sel;
          comm_nxt  = CMD_WRITE;
          addr_nxt  = ADDR_BASE + 4'(sel);
          // A write landing on the grant edge is the freshest value.
          data_nxt  = (wr_hit && wr_chan == sel) ? wr_data : shadow[sel];
        end
      end
      S_LOAD: begin
        pending_nxt[grant] = 1'b0;
        ptr_nxt   = (grant == CHW'(NUM_CH - 1)) ? '0 : grant + CHW'(1);
        state_nxt = S_ACTIVE;
        cnt_nxt   = CW'(FRAME_CYCLES - 1);
      end
      S_ACTIVE: begin
        if (cnt == '0) begin
          state_nxt = S_GAP;
          cnt_nxt   = CW'(GAP_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // A write in the same cycle re-arms the channel after the LOAD clear.
    if (wr_hit) pending_nxt[wr_chan] = 1'b1;

    ext_nxt  = (state_nxt == S_ACTIVE);
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_GAP) && (cnt_nxt == '0);
    if (done_nxt) done_chan_nxt = grant_nxt;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      grant        <= '0;
      ptr          <= '0;
      pending      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_chan    <= '0;
      dac_comm     <= '0;
      dac_addr     <= '0;
      dac_data     <= '0;
      dac_ext_ctrl <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      grant        <= grant_nxt;
      ptr          <= ptr_nxt;
      pending      <= pending_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      done_chan    <= done_chan_nxt;
      dac_comm     <= comm_nxt;
      dac_addr     <= addr_nxt;
      dac_data     <= data_nxt;
      dac_ext_ctrl <= ext_nxt;
    end
  end

endmodule

// File: tb/tb_dac_cmd_scheduler.sv
// Directed bench for dac_cmd_scheduler: default-size instance plus a
// three-channel instance for out-of-range channel handling.
module tb_dac_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, enable, wr_valid;
  logic [1:0]  wr_chan;
  logic [15:0] wr_data;
  logic [3:0]  pending;
  logic        busy, done;
  logic [1:0]  done_chan;
  logic [3:0]  dac_comm, dac_addr;
  logic [15:0] dac_data;
  logic        dac_ext_ctrl;

  logic        wr_valid3;
  logic [1:0]  wr_chan3;
  logic [2:0]  pending3;
  logic        busy3, done3;
  logic [1:0]  done_chan3;
  logic [3:0]  dac_comm3, dac_addr3;
  logic [15:0] dac_data3;
  logic        dac_ext_ctrl3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dac_cmd_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid),
    .wr_chan(wr_chan), .wr_data(wr_data), .pending(pending), .busy(busy),
    .done(done), .done_chan(done_chan), .dac_comm(dac_comm),
    .dac_addr(dac_addr), .dac_data(dac_data), .dac_ext_ctrl(dac_ext_ctrl)
  );

  dac_cmd_scheduler #(.NUM_CH(3), .FRAME_CYCLES(5), .GAP_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(1'b1), .wr_valid(wr_valid3),
    .wr_chan(wr_chan3), .wr_data(16'hBEEF), .pending(pending3), .busy(busy3),
    .done(done3), .done_chan(done_chan3), .dac_comm(dac_comm3),
    .dac_addr(dac_addr3), .dac_data(dac_data3), .dac_ext_ctrl(dac_ext_ctrl3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] d);
    wr_valid = 1'b1;
    wr_chan  = ch;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_rise(input string tag, input logic [3:0] exp_addr, input logic [15:0] exp_data);
    int n = 0;
    while (dac_ext_ctrl !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    check({tag, "_rise"}, 32'(dac_ext_ctrl), 32'd1);
    check({tag, "_addr"}, 32'(dac_addr), 32'(exp_addr));
    check({tag, "_data"}, 32'(dac_data), 32'(exp_data));
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp_ch);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_chan"}, 32'(done_chan), 32'(exp_ch));
  endtask

  initial begin
    int n;
    enable = 1'b1; wr_valid = 1'b0; wr_chan = '0; wr_data = '0;
    wr_valid3 = 1'b0; wr_chan3 = '0;
    do_reset();

    // Reset state
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ext", 32'(dac_ext_ctrl), 32'h0);
    check("rst_addr", 32'(dac_addr), 32'h0);
    check("rst_done", 32'(done), 32'h0);

    // Single write to channel 2, exact frame timing
    wr(2'd2, 16'hA5C3);
    check("t1_pending_set", 32'(pending), 32'h4);
    check("t1_idle", 32'(busy), 32'h0);
    step();
    check("t1_load_busy", 32'(busy), 32'h1);
    check("t1_load_ext", 32'(dac_ext_ctrl), 32'h0);
    check("t1_load_comm", 32'(dac_comm), 32'h3);
    check("t1_load_addr", 32'(dac_addr), 32'h2);
    check("t1_load_data", 32'(dac_data), 32'hA5C3);
    step();
    check("t1_active_ext", 32'(dac_ext_ctrl), 32'h1);
    check("t1_pending_clr", 32'(pending), 32'h0);
    n = 0;
    while (dac_ext_ctrl === 1'b1 && n < 5000) begin
      n++;
      step();
    end
    check("t1_high_len", 32'(n), 32'd2080);
    check("t1_gap_data", 32'(dac_data), 32'hA5C3);
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("t1_gap_len", 32'(n), 32'd16);
    check("t1_done_chan", 32'(done_chan), 32'h2);
    step();
    check("t1_done_pulse", 32'(done), 32'h0);
    check("t1_end_busy", 32'(busy), 32'h0);

    // Round-robin order 0,1,3 then wrap
    do_reset();
    wr(2'd0, 16'h0A00);
    wr(2'd1, 16'h0A01);
    wr(2'd3, 16'h0A03);
    wait_rise("t2_f0", 4'h0, 16'h0A00);
    wait_done("t2_f0", 2'd0);
    wait_rise("t2_f1", 4'h1, 16'h0A01);
    wait_done("t2_f1", 2'd1);
    wait_rise("t2_f3", 4'h3, 16'h0A03);
    wait_done("t2_f3", 2'd3);
    enable = 1'b0;
    wr(2'd2, 16'h0B02);
    wr(2'd0, 16'h0B00);
    check("t2_hold_pending", 32'(pending), 32'h5);
    enable = 1'b1;
    wait_rise("t2_wrap0", 4'h0, 16'h0B00);
    wait_done("t2_wrap0", 2'd0);
    wait_rise("t2_then2", 4'h2, 16'h0B02);
    wait_done("t2_then2", 2'd2);

    // Coalesced writes: one frame with the last value
    do_reset();
    enable = 1'b0;
    wr(2'd1, 16'h1111);
    wr(2'd1, 16'h2222);
    check("t3_pending", 32'(pending), 32'h2);
    enable = 1'b1;
    wait_rise("t3", 4'h1, 16'h2222);
    wait_done("t3", 2'd1);
    for (int i = 0; i < 5; i++) step();
    check("t3_no_second_busy", 32'(busy), 32'h0);
    check("t3_no_second_pend", 32'(pending), 32'h0);

    // Write to the channel while its frame is ACTIVE
    do_reset();
    wr(2'd1, 16'hAAAA);
    wait_rise("t4a_first", 4'h1, 16'hAAAA);
    for (int i = 0; i < 10; i++) step();
    wr(2'd1, 16'h3333);
    check("t4a_data_kept", 32'(dac_data), 32'hAAAA);
    check("t4a_pending", 32'(pending), 32'h2);
    wait_done("t4a_first", 2'd1);
    check("t4a_gap_data", 32'(dac_data), 32'hAAAA);
    wait_rise("t4a_second", 4'h1, 16'h3333);
    wait_done("t4a_second", 2'd1);

    // Same, with the write landing exactly in LOAD
    do_reset();
    wr(2'd1, 16'hBBBB);
    step();
    check("t4b_in_load", 32'({busy, dac_ext_ctrl}), 32'h2);
    wr(2'd1, 16'h3333);
    check("t4b_active", 32'(dac_ext_ctrl), 32'h1);
    check("t4b_pending_kept", 32'(pending), 32'h2);
    check("t4b_data_kept", 32'(dac_data), 32'hBBBB);
    wait_done("t4b_first", 2'd1);
    wait_rise("t4b_second", 4'h1, 16'h3333);
    wait_done("t4b_second", 2'd1);

    // enable gating and mid-frame enable drop
    do_reset();
    enable = 1'b0;
    wr(2'd0, 16'h1000);
    wr(2'd1, 16'h1001);
    wr(2'd2, 16'h1002);
    wr(2'd3, 16'h1003);
    for (int i = 0; i < 5; i++) step();
    check("t5_no_grant", 32'(busy), 32'h0);
    check("t5_pending_all", 32'(pending), 32'hF);
    enable = 1'b1;
    wait_rise("t5_f0", 4'h0, 16'h1000);
    enable = 1'b0;
    wait_done("t5_f0", 2'd0);
    for (int i = 0; i < 20; i++) step();
    check("t5_held_busy", 32'(busy), 32'h0);
    check("t5_held_pending", 32'(pending), 32'hE);
    enable = 1'b1;
    wait_rise("t5_f1", 4'h1, 16'h1001);

    // Reset mid-ACTIVE
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    step();
    check("t6_rst_ext", 32'(dac_ext_ctrl), 32'h0);
    check("t6_rst_pending", 32'(pending), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_data", 32'(dac_data), 32'h0);
    rst_n = 1'b1;
    step();

    // Out-of-range channel on the three-channel instance
    wr_valid3 = 1'b1;
    wr_chan3  = 2'd3;
    step();
    wr_valid3 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("t7_bad_pending", 32'(pending3), 32'h0);
    check("t7_bad_busy", 32'(busy3), 32'h0);
    wr_valid3 = 1'b1;
    wr_chan3  = 2'd2;
    step();
    wr_valid3 = 1'b0;
    check("t7_good_pending", 32'(pending3), 32'h4);
    step();
    check("t7_good_addr", 32'(dac_addr3), 32'h2);
    check("t7_good_data", 32'(dac_data3), 32'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
